// File: rtl/hazard_ctrl_if.sv
// Pipeline status and hazard-control signals between the integer pipeline and hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              cnt_clr;
  logic              id_valid;
  logic [INST_W-1:0] id_inst;
  logic              ex_valid;
  logic              ex_is_ld;
  logic [4:0]        ex_rd;
  logic              ex_br_taken;
  logic              dmem_req;
  logic              dmem_ack;

  logic              pc_we;
  logic              pc_sel_br;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              pipe_we;
  logic [CNT_W-1:0]  cnt_stall;
  logic [CNT_W-1:0]  cnt_flush;
  logic [CNT_W-1:0]  cnt_memwait;

  modport master (
    output cnt_clr, id_valid, id_inst, ex_valid, ex_is_ld, ex_rd,
           ex_br_taken, dmem_req, dmem_ack,
    input  pc_we, pc_sel_br, ifid_we, ifid_flush, idex_bubble, pipe_we,
           cnt_stall, cnt_flush, cnt_memwait
  );

  modport slave (
    input  cnt_clr, id_valid, id_inst, ex_valid, ex_is_ld, ex_rd,
           ex_br_taken, dmem_req, dmem_ack,
    output pc_we, pc_sel_br, ifid_we, ifid_flush, idex_bubble, pipe_we,
           cnt_stall, cnt_flush, cnt_memwait
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush and data-memory freeze control for the 5-stage RV64 pipeline,
// with saturating event counters.
module hazard_ctrl #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  localparam logic [6:0] LD      = 7'b0000011;
  localparam logic [6:0] SD      = 7'b0100011;
  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] ALU_IMM = 7'b0010011;
  localparam logic [6:0] ALU     = 7'b0110011;

  typedef enum logic [1:0] {INIT = 2'd0, RUN = 2'd1, MEM_WAIT = 2'd2} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [6:0]       opcode;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             use_rs1;
  logic             use_rs2;
  logic             load_use;
  logic             br_take;
  logic             freeze;
  logic             pc_we;
  logic             pc_sel_br;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_we;
  logic             stall_evt;
  logic             flush_evt;
  logic             wait_evt;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;
  logic [CNT_W-1:0] cnt_memwait;
  logic             unused_inst_bits;

  assign opcode           = bus.id_inst[6:0];
  assign rs1              = bus.id_inst[19:15];
  assign rs2              = bus.id_inst[24:20];
  assign unused_inst_bits = ^{bus.id_inst[INST_W-1:25], bus.id_inst[14:7]};

  // Which register fields are real sources; rs2 of loads/immediates is immediate bits.
  always_comb begin : src_decode
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      LD, ALU_IMM:     use_rs1 = 1'b1;
      SD, BRANCH, ALU: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use = bus.id_valid & bus.ex_valid & bus.ex_is_ld & (bus.ex_rd != 5'd0) &
                    ((use_rs1 & (rs1 == bus.ex_rd)) | (use_rs2 & (rs2 == bus.ex_rd)));
  assign br_take  = bus.ex_valid & bus.ex_br_taken;

  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin : fsm_comb
    state_nxt   = RUN;
    freeze      = 1'b0;
    pc_we       = 1'b0;
    pc_sel_br   = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_we     = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    wait_evt    = 1'b0;
    if (rst || state == INIT) begin
      state_nxt   = rst ? INIT : RUN;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      freeze = (state == MEM_WAIT) ? ~bus.dmem_ack : (bus.dmem_req & ~bus.dmem_ack);
      if (freeze) begin
        state_nxt = MEM_WAIT;
        wait_evt  = 1'b1;
      end else if (br_take) begin
        pc_sel_br   = 1'b1;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        pipe_we     = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        idex_bubble = 1'b1;
        pipe_we     = 1'b1;
        stall_evt   = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        pipe_we = 1'b1;
      end
    end
  end

  // Saturating counters; clear and reset win over any event in the same cycle.
  always_ff @(posedge clk) begin : counters
    if (rst || bus.cnt_clr) begin
      cnt_stall   <= '0;
      cnt_flush   <= '0;
      cnt_memwait <= '0;
    end else begin
      if (stall_evt && (cnt_stall != '1))   cnt_stall   <= cnt_stall + CNT_W'(1);
      if (flush_evt && (cnt_flush != '1))   cnt_flush   <= cnt_flush + CNT_W'(1);
      if (wait_evt  && (cnt_memwait != '1)) cnt_memwait <= cnt_memwait + CNT_W'(1);
    end
  end

  assign bus.pc_we       = pc_we;
  assign bus.pc_sel_br   = pc_sel_br;
  assign bus.ifid_we     = ifid_we;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.pipe_we     = pipe_we;
  assign bus.cnt_stall   = cnt_stall;
  assign bus.cnt_flush   = cnt_flush;
  assign bus.cnt_memwait = cnt_memwait;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: decode/priority vector table plus multi-cycle sequences.
module tb_hazard_ctrl;
  localparam int unsigned INST_W = 32;
  localparam int unsigned CNT_W  = 4;

  // Control vector order: {pc_we, pc_sel_br, ifid_we, ifid_flush, idex_bubble, pipe_we}
  localparam logic [5:0] C_NORM = 6'b101001;
  localparam logic [5:0] C_LU   = 6'b000011;
  localparam logic [5:0] C_BR   = 6'b111111;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_INIT = 6'b000110;

  typedef struct {
    string       name;
    logic        id_valid;
    logic [31:0] inst;
    logic        ex_valid;
    logic        ex_is_ld;
    logic [4:0]  ex_rd;
    logic        br;
    logic        req;
    logic        ack;
    logic [5:0]  exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t vecs[18];

  hazard_ctrl_if #(.INST_W(INST_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.INST_W(INST_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string name, input logic [5:0] exp);
    logic [5:0] act;
    #1;
    act = {bus.pc_we, bus.pc_sel_br, bus.ifid_we, bus.ifid_flush, bus.idex_bubble, bus.pipe_we};
    check(name, 32'(act), 32'(exp));
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] st,
                           input logic [CNT_W-1:0] fl, input logic [CNT_W-1:0] mw);
    check({name, "_stall"},   32'(bus.cnt_stall),   32'(st));
    check({name, "_flush"},   32'(bus.cnt_flush),   32'(fl));
    check({name, "_memwait"}, 32'(bus.cnt_memwait), 32'(mw));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic idv, input logic [31:0] inst, input logic exv, input logic exld,
                       input logic [4:0] rd, input logic br, input logic req, input logic ack);
    bus.id_valid    = idv;
    bus.id_inst     = inst;
    bus.ex_valid    = exv;
    bus.ex_is_ld    = exld;
    bus.ex_rd       = rd;
    bus.ex_br_taken = br;
    bus.dmem_req    = req;
    bus.dmem_ack    = ack;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0000_0013, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lu(input logic br, input logic req, input logic ack);
    drive(1'b1, 32'h0062_83B3, 1'b1, 1'b1, 5'd5, br, req, ack);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0]  = '{"add_rs1_hit",    1'b1, 32'h0062_83B3, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[1]  = '{"add_rs2_hit",    1'b1, 32'h0053_03B3, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[2]  = '{"addi_imm_miss",  1'b1, 32'h0050_8393, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[3]  = '{"addi_rs1_hit",   1'b1, 32'h0050_8393, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[4]  = '{"ld_imm_miss",    1'b1, 32'h0051_3383, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[5]  = '{"ld_rs1_hit",     1'b1, 32'h0051_3383, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[6]  = '{"sd_rs2_hit",     1'b1, 32'h0053_3023, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[7]  = '{"beq_rs2_hit",    1'b1, 32'h0062_8063, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[8]  = '{"lui_no_src",     1'b1, 32'h0002_82B7, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[9]  = '{"x0_no_stall",    1'b1, 32'h0000_03B3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[10] = '{"id_invalid",     1'b0, 32'h0062_83B3, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[11] = '{"ex_not_load",    1'b1, 32'h0062_83B3, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[12] = '{"ex_invalid",     1'b1, 32'h0062_83B3, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM};
    vecs[13] = '{"br_over_lu",     1'b1, 32'h0062_83B3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR};
    vecs[14] = '{"br_ex_invalid",  1'b1, 32'h0062_83B3, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_NORM};
    vecs[15] = '{"req_ack_same",   1'b1, 32'h0000_0013, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NORM};
    vecs[16] = '{"req_freeze",     1'b1, 32'h0062_83B3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_FRZ};
    vecs[17] = '{"ack_then_br",    1'b1, 32'h0062_83B3, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, C_BR};

    // Reset: INIT outputs during reset and one cycle after
    rst         = 1'b1;
    bus.cnt_clr = 1'b0;
    idle();
    step();
    check_ctl("rst_cyc1", C_INIT);
    step();
    check_ctl("rst_cyc2", C_INIT);
    check_cnt("rst", '0, '0, '0);
    rst = 1'b0;
    check_ctl("init_after_rst", C_INIT);
    step();
    check_ctl("run_idle", C_NORM);

    foreach (vecs[i]) begin
      step();
      drive(vecs[i].id_valid, vecs[i].inst, vecs[i].ex_valid, vecs[i].ex_is_ld,
            vecs[i].ex_rd, vecs[i].br, vecs[i].req, vecs[i].ack);
      check_ctl(vecs[i].name, vecs[i].exp);
    end

    // Clear counters left by the table
    step();
    idle();
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    check_cnt("clr", '0, '0, '0);

    // One-cycle load-use stall
    lu(1'b0, 1'b0, 1'b0);
    check_ctl("lu_stall", C_LU);
    step();
    check_cnt("lu", 4'd1, '0, '0);
    bus.ex_is_ld = 1'b0;
    check_ctl("lu_release", C_NORM);
    step();
    check_cnt("lu_after", 4'd1, '0, '0);

    // Branch beats coincident load-use
    lu(1'b1, 1'b0, 1'b0);
    check_ctl("br_prio", C_BR);
    step();
    check_cnt("br", 4'd1, 4'd1, '0);

    // Three frozen cycles then ack
    idle();
    bus.dmem_req = 1'b1;
    check_ctl("mw_f0", C_FRZ);
    step();
    check_ctl("mw_f1", C_FRZ);
    step();
    check_ctl("mw_f2", C_FRZ);
    step();
    bus.dmem_ack = 1'b1;
    check_ctl("mw_ack", C_NORM);
    step();
    idle();
    check_cnt("mw", 4'd1, 4'd1, 4'd3);

    // Req with ack in the same cycle never freezes
    bus.dmem_req = 1'b1;
    bus.dmem_ack = 1'b1;
    check_ctl("mw_same", C_NORM);
    step();
    idle();
    check_cnt("mw_same", 4'd1, 4'd1, 4'd3);

    // Branch held through freeze acts only in the ack cycle
    lu(1'b1, 1'b1, 1'b0);
    check_ctl("mwb_f0", C_FRZ);
    step();
    check_ctl("mwb_f1", C_FRZ);
    step();
    bus.dmem_ack = 1'b1;
    check_ctl("mwb_ack", C_BR);
    step();
    idle();
    check_cnt("mwb", 4'd1, 4'd2, 4'd5);

    // Reset in the middle of a freeze
    bus.dmem_req = 1'b1;
    step();
    rst = 1'b1;
    step();
    check_ctl("rst_mid_init", C_INIT);
    check_cnt("rst_mid", '0, '0, '0);
    rst = 1'b0;
    check_ctl("rst_mid_init2", C_INIT);
    step();
    idle();
    check_ctl("rst_mid_run", C_NORM);

    // Saturation of the stall counter
    lu(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 15; c++) step();
    check_cnt("sat15", 4'd15, '0, '0);
    check_ctl("sat_still_stall", C_LU);
    step();
    check_cnt("sat16", 4'd15, '0, '0);
    step();
    check_cnt("sat17", 4'd15, '0, '0);

    lu(1'b1, 1'b0, 1'b0);
    step();
    idle();
    bus.dmem_req = 1'b1;
    step();
    bus.dmem_ack = 1'b1;
    step();
    check_cnt("pre_clr", 4'd15, 4'd1, 4'd1);

    // Clear wins over a same-cycle event
    lu(1'b0, 1'b0, 1'b0);
    bus.cnt_clr = 1'b1;
    step();
    bus.cnt_clr = 1'b0;
    idle();
    check_cnt("clr_final", '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
